// File: rtl/haar_pkg.sv
// Shared constants and types for the HAAR integral-window producer and the
// downstream cascade comparator.
//   HAAR_WIN_W / HAAR_WIN_H / HAAR_WIN_SIZE : window geometry
//   HAAR_PIX_W / HAAR_II_W                  : pixel and integral entry widths
//   ii_t                                    : one integral image entry
//   ii_state_t                              : producer state (load / done)
package haar_pkg;

   localparam int unsigned HAAR_WIN_W    = 20;
   localparam int unsigned HAAR_WIN_H    = 20;
   localparam int unsigned HAAR_WIN_SIZE = HAAR_WIN_W * HAAR_WIN_H;
   localparam int unsigned HAAR_PIX_W    = 8;
   localparam int unsigned HAAR_II_W     = 32;

   typedef logic [31:0] ii_t;

   typedef enum logic [0:0] {
      StLoad,
      StDone
   } ii_state_t;

   // Bits needed to hold the sum of n maximal unsigned pixels.
   function automatic int unsigned sum_width(input int unsigned n, input int unsigned pix_w);
      return $clog2(n * ((1 << pix_w) - 1) + 1);
   endfunction

endpackage

// File: rtl/haar_integral_builder_if.sv
// Pixel stream and buffer handshake between the upstream source / downstream
// comparator and the integral builder.
//   PIX_DATA, PIX_VALID, PIX_SOF : raster pixel stream into the builder
//   PIX_READY                    : builder accepts a pixel this cycle
//   RELEASE                      : consumer is finished with the frozen buffer
//   START                        : buffer complete and stable
// master = environment side, slave = builder side.
interface haar_integral_builder_if #(
   parameter int unsigned PIX_W = 8
) ();

   logic [PIX_W-1:0] PIX_DATA;
   logic             PIX_VALID;
   logic             PIX_SOF;
   logic             PIX_READY;
   logic             RELEASE;
   logic             START;

   modport master (
      output PIX_DATA, PIX_VALID, PIX_SOF, RELEASE,
      input  PIX_READY, START
   );

   modport slave (
      input  PIX_DATA, PIX_VALID, PIX_SOF, RELEASE,
      output PIX_READY, START
   );

endinterface

// File: rtl/haar_window_counter.sv
// Raster x/y position counter for one window.
//   clk_i, rst_i : clock, synchronous active-high reset
//   advance_i    : a pixel is accepted this cycle
//   sof_i        : accepted pixel carries start-of-frame (already qualified)
//   x_o, y_o     : effective position of the current pixel (SOF forces 0,0)
//   last_o       : current pixel is the final one of the window
//   restart_o    : SOF arrived somewhere other than (0,0)
module haar_window_counter #(
   parameter int unsigned WIN_W = 20,
   parameter int unsigned WIN_H = 20,
   localparam int unsigned XW   = $clog2(WIN_W),
   localparam int unsigned YW   = $clog2(WIN_H)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          advance_i,
   input  logic          sof_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          last_o,
   output logic          restart_o
);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   assign restart_o = sof_i & ((x_q != '0) | (y_q != '0));
   assign x_o       = sof_i ? '0 : x_q;
   assign y_o       = sof_i ? '0 : y_q;
   assign last_o    = (x_o == XW'(WIN_W - 1)) & (y_o == YW'(WIN_H - 1));

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (advance_i) begin
         if (last_o) begin
            x_d = '0;
            y_d = '0;
         end else if (x_o == XW'(WIN_W - 1)) begin
            x_d = '0;
            y_d = y_o + 1'b1;
         end else begin
            x_d = x_o + 1'b1;
            y_d = y_o;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/haar_integral_builder.sv
// Builds the summed-area image of a raster-ordered window, one pixel per
// cycle, then holds it frozen with START high until RELEASE.
//   Clk, Reset      : clock, synchronous active-high reset
//   pix             : pixel stream / START-RELEASE handshake (slave side)
//   integral_buffer : entry y*WIN_W+x = sum of pixels (0..x, 0..y)
//   SOF_ERR         : sticky, a window was restarted before completion
module haar_integral_builder
   import haar_pkg::*;
#(
   parameter int unsigned WIN_W = HAAR_WIN_W,
   parameter int unsigned WIN_H = HAAR_WIN_H,
   parameter int unsigned PIX_W = HAAR_PIX_W,
   parameter int unsigned II_W  = HAAR_II_W
) (
   input  logic                  Clk,
   input  logic                  Reset,
   haar_integral_builder_if.slave pix,
   output logic [II_W-1:0]       integral_buffer [WIN_W*WIN_H],
   output logic                  SOF_ERR
);

   localparam int unsigned WinSize = WIN_W * WIN_H;
   localparam int unsigned RowW    = sum_width(WIN_W, PIX_W);
   localparam int unsigned SumW    = sum_width(WinSize, PIX_W);
   localparam int unsigned IdxW    = $clog2(WinSize);
   localparam int unsigned XW      = $clog2(WIN_W);
   localparam int unsigned YW      = $clog2(WIN_H);

   ii_state_t       state_q, state_d;
   logic [RowW-1:0] row_sum_q, row_sum_new;
   logic [SumW-1:0] buf_q [WinSize];
   logic [SumW-1:0] above, entry_new;
   logic [IdxW-1:0] idx;
   logic [XW-1:0]   x;
   logic [YW-1:0]   y;
   logic            accept, last, restart;

   assign pix.PIX_READY = (state_q == StLoad) & ~Reset;
   assign pix.START     = (state_q == StDone);
   assign accept        = pix.PIX_VALID & pix.PIX_READY;

   haar_window_counter #(
      .WIN_W (WIN_W),
      .WIN_H (WIN_H)
   ) u_counter (
      .clk_i     (Clk),
      .rst_i     (Reset),
      .advance_i (accept),
      .sof_i     (accept & pix.PIX_SOF),
      .x_o       (x),
      .y_o       (y),
      .last_o    (last),
      .restart_o (restart)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad: if (accept && last) state_d = StDone;
         StDone: if (pix.RELEASE) state_d = StLoad;
         default: state_d = StLoad;
      endcase
   end

   // Previous-row entry is read straight out of the buffer one row back.
   always_comb begin
      row_sum_new = ((x == '0) ? '0 : row_sum_q) + RowW'(pix.PIX_DATA);
      idx         = IdxW'(y) * IdxW'(WIN_W) + IdxW'(x);
      above       = (y == '0) ? '0 : buf_q[idx - IdxW'(WIN_W)];
      entry_new   = SumW'(row_sum_new) + above;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= StLoad;
         row_sum_q <= '0;
         SOF_ERR   <= 1'b0;
         for (int i = 0; i < WinSize; i++) buf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            row_sum_q  <= row_sum_new;
            buf_q[idx] <= entry_new;
         end
         if (restart) SOF_ERR <= 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < WinSize; i++) integral_buffer[i] = II_W'(buf_q[i]);
   end

endmodule

// File: tb/tb_haar_integral_builder.sv
// Directed bench for haar_integral_builder: stimulus pushes expected windows
// into a scoreboard queue, a monitor pops and checks them when START rises.
module tb_haar_integral_builder;
   import haar_pkg::*;

   localparam int W = HAAR_WIN_W;
   localparam int N = HAAR_WIN_SIZE;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] ib [N];
   logic        SOF_ERR;

   always #5 Clk = ~Clk;

   haar_integral_builder_if #(.PIX_W(8)) pix ();

   haar_integral_builder dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .pix             (pix),
      .integral_buffer (ib),
      .SOF_ERR         (SOF_ERR)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   typedef struct {
      string name;
      int    i0, v0, i1, v1, i2, v2;
   } win_t;

   win_t exp_q[$];
   win_t w;

   // Monitor: samples 1 time unit before each rising edge.
   int cycle    = 0;
   int last_acc = -10;
   int acc_cnt  = 0;
   bit start_prev = 1'b0;

   initial begin
      forever begin
         @(negedge Clk);
         #4;
         cycle++;
         if (pix.START && !start_prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_start", 1, 0);
            end else begin
               w = exp_q.pop_front();
               chk({w.name, "_latency"}, cycle - last_acc, 1);
               chk({w.name, "_accepts"}, acc_cnt, N);
               chk({w.name, "_entryA"}, ib[w.i0], w.v0);
               chk({w.name, "_entryB"}, ib[w.i1], w.v1);
               chk({w.name, "_entryC"}, ib[w.i2], w.v2);
            end
            acc_cnt = 0;
         end
         start_prev = pix.START;
         if (Reset) begin
            acc_cnt = 0;
         end else if (pix.PIX_VALID && pix.PIX_READY) begin
            acc_cnt  = pix.PIX_SOF ? 1 : acc_cnt + 1;
            last_acc = cycle;
         end
      end
   end

   task automatic drive_idle();
      pix.PIX_VALID = 1'b0;
      pix.PIX_SOF   = 1'b0;
      pix.PIX_DATA  = '0;
      pix.RELEASE   = 1'b0;
   endtask

   function automatic logic [7:0] pixval(input int kind, input int x);
      case (kind)
         0:       return 8'd1;
         1:       return 8'd255;
         default: return x[7:0];
      endcase
   endfunction

   // kind: 0 ones, 1 all-255, 2 x ramp. rel_at: pixel index to pulse RELEASE.
   task automatic send(input int kind, input bit gaps, input bit sof_first, input int npix,
                       input int rel_at);
      int p = 0;
      int wait_c = 0;
      while (p < npix) begin
         @(negedge Clk);
         pix.RELEASE = (p == rel_at);
         if (gaps && $urandom_range(0, 3) == 0) begin
            pix.PIX_VALID = 1'b0;
            pix.PIX_SOF   = 1'b0;
         end else begin
            pix.PIX_VALID = 1'b1;
            pix.PIX_DATA  = pixval(kind, p % W);
            pix.PIX_SOF   = sof_first && (p == 0);
         end
         #1;
         if (pix.PIX_VALID && pix.PIX_READY) begin
            p++;
            wait_c = 0;
         end else begin
            wait_c++;
            if (wait_c > 100) begin
               chk("pixel_accept_timeout", p, npix);
               drive_idle();
               return;
            end
         end
      end
      @(negedge Clk);
      drive_idle();
   endtask

   task automatic wait_start(input string name);
      for (int i = 0; i < 5; i++) begin
         if (pix.START) break;
         @(negedge Clk);
         #1;
      end
      chk({name, "_start_seen"}, pix.START, 1);
      chk({name, "_ready_in_done"}, pix.PIX_READY, 0);
   endtask

   task automatic release_buf(input string name);
      @(negedge Clk);
      pix.RELEASE = 1'b1;
      @(negedge Clk);
      pix.RELEASE = 1'b0;
      #1;
      chk({name, "_ready_after_release"}, pix.PIX_READY, 1);
      chk({name, "_start_after_release"}, pix.START, 0);
   endtask

   initial begin
      int acc;
      drive_idle();
      Reset = 1'b1;
      @(negedge Clk);
      @(negedge Clk);
      #1;
      chk("reset_ready", pix.PIX_READY, 0);
      chk("reset_start", pix.START, 0);
      chk("reset_sof_err", SOF_ERR, 0);
      chk("reset_entry0", ib[0], 0);
      chk("reset_entry399", ib[399], 0);
      Reset = 1'b0;
      #1;
      chk("ready_after_reset", pix.PIX_READY, 1);

      // All ones, no stalls.
      exp_q.push_back(win_t'{"ones", 19, 20, 20, 2, 399, 400});
      send(0, 1'b0, 1'b1, N, -1);
      wait_start("ones");
      release_buf("ones");

      // All 255 with gaps, no SOF, RELEASE pulsed mid-load.
      exp_q.push_back(win_t'{"full255", 399, 102000, 0, 255, 21, 1020});
      send(1, 1'b1, 1'b0, N, 123);
      wait_start("full255");
      chk("full255_sof_err", SOF_ERR, 0);
      release_buf("full255");

      // x ramp, then hold DONE with pixels offered.
      exp_q.push_back(win_t'{"ramp", 19, 190, 399, 3800, 20, 0});
      send(2, 1'b0, 1'b1, N, -1);
      wait_start("ramp");
      acc = 0;
      repeat (50) begin
         @(negedge Clk);
         pix.PIX_VALID = 1'b1;
         pix.PIX_DATA  = 8'h55;
         pix.PIX_SOF   = 1'b1;
         #1;
         if (pix.PIX_VALID && pix.PIX_READY) acc++;
      end
      drive_idle();
      chk("hold_accepts", acc, 0);
      chk("hold_start", pix.START, 1);
      chk("hold_entry19", ib[19], 190);
      chk("hold_entry399", ib[399], 3800);
      chk("hold_entry20", ib[20], 0);
      chk("hold_entry0", ib[0], 0);
      release_buf("ramp");

      // SOF restart at pixel 137.
      send(0, 1'b0, 1'b1, 137, -1);
      chk("sof_err_before_restart", SOF_ERR, 0);
      exp_q.push_back(win_t'{"restart", 399, 400, 19, 20, 20, 2});
      send(0, 1'b0, 1'b1, N, -1);
      chk("sof_err_set", SOF_ERR, 1);
      wait_start("restart");
      release_buf("restart");
      chk("sof_err_sticky", SOF_ERR, 1);

      // Reset mid-frame.
      send(1, 1'b0, 1'b1, 250, -1);
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      chk("midframe_ready_in_reset", pix.PIX_READY, 0);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("midframe_sof_err", SOF_ERR, 0);
      chk("midframe_start", pix.START, 0);
      chk("midframe_entry0", ib[0], 0);
      chk("midframe_entry21", ib[21], 0);
      chk("midframe_ready", pix.PIX_READY, 1);

      // Reset during DONE.
      exp_q.push_back(win_t'{"pre_reset", 19, 20, 20, 2, 399, 400});
      send(0, 1'b0, 1'b1, N, -1);
      wait_start("pre_reset");
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      chk("done_reset_start", pix.START, 0);
      chk("done_reset_entry399", ib[399], 0);
      chk("done_reset_ready", pix.PIX_READY, 1);

      // Full window after resets, ramp with gaps.
      exp_q.push_back(win_t'{"ramp2", 19, 190, 399, 3800, 20, 0});
      send(2, 1'b1, 1'b1, N, -1);
      wait_start("ramp2");
      release_buf("ramp2");

      repeat (3) @(negedge Clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
